// File: rtl/inst_pkg.sv
// Shared types, opcode constants and RV32I field-packing helpers for the instruction encoder.
package inst_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned FMT_W = 4;

   // Field-bundle format selector; codes above FMT_MRET are illegal.
   typedef enum logic [FMT_W-1:0] {
      FMT_R    = 4'd0,
      FMT_I    = 4'd1,
      FMT_S    = 4'd2,
      FMT_B    = 4'd3,
      FMT_U    = 4'd4,
      FMT_J    = 4'd5,
      FMT_LI   = 4'd6,
      FMT_CSR  = 4'd7,
      FMT_MRET = 4'd8
   } fmt_t;

   // LI expansion state.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_LI_LO = 1'b1
   } li_state_t;

   localparam logic [6:0]      OP_LUI    = 7'b0110111;
   localparam logic [6:0]      OP_IMM    = 7'b0010011;
   localparam logic [6:0]      OP_SYSTEM = 7'b1110011;
   localparam logic [XLEN-1:0] MRET_WORD = 32'h3020_0073;

   // One output-buffer entry.
   typedef struct packed {
      logic            last;
      logic [XLEN-1:0] instr;
   } skid_ent_t;

   function automatic logic [XLEN-1:0] pack_r(input logic [6:0] funct7, input logic [4:0] rs2,
                                              input logic [4:0] rs1, input logic [2:0] funct3,
                                              input logic [4:0] rd, input logic [6:0] opcode);
      return {funct7, rs2, rs1, funct3, rd, opcode};
   endfunction

   function automatic logic [XLEN-1:0] pack_i(input logic [11:0] imm, input logic [4:0] rs1,
                                              input logic [2:0] funct3, input logic [4:0] rd,
                                              input logic [6:0] opcode);
      return {imm, rs1, funct3, rd, opcode};
   endfunction

   function automatic logic [XLEN-1:0] pack_s(input logic [11:0] imm, input logic [4:0] rs2,
                                              input logic [4:0] rs1, input logic [2:0] funct3,
                                              input logic [6:0] opcode);
      return {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
   endfunction

   // Branch offsets are even, so bit 0 is never encoded.
   function automatic logic [XLEN-1:0] pack_b(input logic [12:1] imm, input logic [4:0] rs2,
                                              input logic [4:0] rs1, input logic [2:0] funct3,
                                              input logic [6:0] opcode);
      return {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
   endfunction

   function automatic logic [XLEN-1:0] pack_u(input logic [31:12] imm, input logic [4:0] rd,
                                              input logic [6:0] opcode);
      return {imm, rd, opcode};
   endfunction

   // Jump offsets are even, so bit 0 is never encoded.
   function automatic logic [XLEN-1:0] pack_j(input logic [20:1] imm, input logic [4:0] rd,
                                              input logic [6:0] opcode);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
   endfunction

   function automatic logic [XLEN-1:0] pack_csr(input logic [11:0] csr, input logic [4:0] rs1,
                                                input logic [2:0] funct3, input logic [4:0] rd);
      return {csr, rs1, funct3, rd, OP_SYSTEM};
   endfunction

endpackage

// File: rtl/inst_skid.sv
// Shifting output buffer of {last,instr}; head entry drives the outputs straight from flops.
module inst_skid
   import inst_pkg::*;
#(
   parameter int unsigned SKID_DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  skid_ent_t push_ent,
   output logic      push_ok_c,
   output logic      room_d_c,
   output logic      out_valid,
   output skid_ent_t out_ent,
   input  logic      out_ready
);

   logic [SKID_DEPTH-1:0] vld_q;
   logic [SKID_DEPTH-1:0] vld_d;
   skid_ent_t             ent_q [SKID_DEPTH];
   skid_ent_t             ent_d [SKID_DEPTH];
   logic                  pop;
   logic                  placed;

   // A push is safe when a slot is free or the head leaves this cycle (full push+pop stays full).
   assign pop       = vld_q[0] && out_ready;
   assign push_ok_c = !vld_q[SKID_DEPTH-1] || pop;

   // Shift out the head on pop, then drop a push into the lowest free slot.
   always_comb begin
      vld_d  = vld_q;
      ent_d  = ent_q;
      placed = 1'b0;
      if (pop) begin
         for (int i = 0; i < int'(SKID_DEPTH) - 1; i++) begin
            vld_d[i] = vld_q[i+1];
            ent_d[i] = ent_q[i+1];
         end
         vld_d[SKID_DEPTH-1] = 1'b0;
         ent_d[SKID_DEPTH-1] = '0;
      end
      if (push && push_ok_c) begin
         for (int i = 0; i < int'(SKID_DEPTH); i++) begin
            if (!placed && !vld_d[i]) begin
               vld_d[i] = 1'b1;
               ent_d[i] = push_ent;
               placed   = 1'b1;
            end
         end
      end
   end

   // Guaranteed free slot next cycle regardless of what the consumer does then.
   assign room_d_c = !vld_d[SKID_DEPTH-1];

   // Buffer storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < int'(SKID_DEPTH); i++) begin
            ent_q[i] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         ent_q <= ent_d;
      end
   end

   assign out_valid = vld_q[0];
   assign out_ent   = ent_q[0];

endmodule

// File: rtl/inst_encoder.sv
// Packs decoded instruction fields into RV32I words; expands LI into LUI+ADDI.
// Optional build macro INST_ENC_SYSTEM_EN adds CSR and MRET encodings (illegal otherwise).
module inst_encoder
   import inst_pkg::*;
#(
   parameter int unsigned SKID_DEPTH = 2
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        IN_VALID,
   output logic        IN_READY,
   input  logic [3:0]  IN_FMT,
   input  logic [6:0]  IN_OPCODE,
   input  logic [2:0]  IN_FUNCT3,
   input  logic [6:0]  IN_FUNCT7,
   input  logic [4:0]  IN_RD,
   input  logic [4:0]  IN_RS1,
   input  logic [4:0]  IN_RS2,
   input  logic [31:0] IN_IMM,
   output logic        OUT_VALID,
   input  logic        OUT_READY,
   output logic [31:0] OUT_INSTR,
   output logic        OUT_LAST,
   output logic        ERR
);

   li_state_t   state_q, state_d;
   logic        in_ready_q, in_ready_d;
   logic        err_q, err_d;
   logic [4:0]  li_rd_q, li_rd_d;
   logic [11:0] li_lo_q, li_lo_d;

   fmt_t        fmt;
   logic        accept;
   logic [19:0] li_hi;
   logic        push;
   skid_ent_t   push_ent;
   logic        push_ok_c;
   logic        room_d_c;
   skid_ent_t   out_ent;

   assign fmt    = fmt_t'(IN_FMT);
   assign accept = IN_VALID && in_ready_q;
   // Upper LI part rounds up when the sign-extended low 12 bits are negative.
   assign li_hi  = IN_IMM[31:12] + 20'(IN_IMM[11]);

   // Pack mux, LI expansion and illegal-format detection.
   always_comb begin
      state_d  = state_q;
      li_rd_d  = li_rd_q;
      li_lo_d  = li_lo_q;
      err_d    = 1'b0;
      push     = 1'b0;
      push_ent = '0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               push          = 1'b1;
               push_ent.last = 1'b1;
               case (fmt)
                  FMT_R: push_ent.instr = pack_r(IN_FUNCT7, IN_RS2, IN_RS1, IN_FUNCT3, IN_RD, IN_OPCODE);
                  FMT_I: push_ent.instr = pack_i(IN_IMM[11:0], IN_RS1, IN_FUNCT3, IN_RD, IN_OPCODE);
                  FMT_S: push_ent.instr = pack_s(IN_IMM[11:0], IN_RS2, IN_RS1, IN_FUNCT3, IN_OPCODE);
                  FMT_B: push_ent.instr = pack_b(IN_IMM[12:1], IN_RS2, IN_RS1, IN_FUNCT3, IN_OPCODE);
                  FMT_U: push_ent.instr = pack_u(IN_IMM[31:12], IN_RD, IN_OPCODE);
                  FMT_J: push_ent.instr = pack_j(IN_IMM[20:1], IN_RD, IN_OPCODE);
                  FMT_LI: begin
                     if (li_hi == 20'd0) begin
                        push_ent.instr = pack_i(IN_IMM[11:0], 5'd0, 3'b000, IN_RD, OP_IMM);
                     end else if (IN_IMM[11:0] == 12'd0) begin
                        push_ent.instr = pack_u(li_hi, IN_RD, OP_LUI);
                     end else begin
                        push_ent.instr = pack_u(li_hi, IN_RD, OP_LUI);
                        push_ent.last  = 1'b0;
                        state_d        = ST_LI_LO;
                        li_rd_d        = IN_RD;
                        li_lo_d        = IN_IMM[11:0];
                     end
                  end
`ifdef INST_ENC_SYSTEM_EN
                  FMT_CSR:  push_ent.instr = pack_csr(IN_IMM[11:0], IN_RS1, IN_FUNCT3, IN_RD);
                  FMT_MRET: push_ent.instr = MRET_WORD;
`endif
                  default: begin
                     push  = 1'b0;
                     err_d = 1'b1;
                  end
               endcase
            end
         end
         ST_LI_LO: begin
            if (push_ok_c) begin
               push           = 1'b1;
               push_ent.last  = 1'b1;
               push_ent.instr = pack_i(li_lo_q, li_rd_q, 3'b000, li_rd_q, OP_IMM);
               state_d        = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Accept only when idle and a slot is guaranteed free next cycle.
   assign in_ready_d = (state_d == ST_IDLE) && room_d_c;

   // Control state registers.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q    <= ST_IDLE;
         in_ready_q <= 1'b0;
         err_q      <= 1'b0;
         li_rd_q    <= '0;
         li_lo_q    <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         err_q      <= err_d;
         li_rd_q    <= li_rd_d;
         li_lo_q    <= li_lo_d;
      end
   end

   inst_skid #(
      .SKID_DEPTH(SKID_DEPTH)
   ) u_skid (
      .clk       (CLK),
      .rst_n     (RSTn),
      .push      (push),
      .push_ent  (push_ent),
      .push_ok_c (push_ok_c),
      .room_d_c  (room_d_c),
      .out_valid (OUT_VALID),
      .out_ent   (out_ent),
      .out_ready (OUT_READY)
   );

   assign IN_READY  = in_ready_q;
   assign OUT_INSTR = out_ent.instr;
   assign OUT_LAST  = out_ent.last;
   assign ERR       = err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: hand-encoded RV32I words, LI expansion, backpressure, reset, ERR.
`timescale 1ns/1ps
module tb_inst_encoder;
   import inst_pkg::*;

   logic        CLK = 1'b0;
   logic        RSTn = 1'b0;
   logic        IN_VALID = 1'b0;
   logic        IN_READY;
   logic [3:0]  IN_FMT = '0;
   logic [6:0]  IN_OPCODE = '0;
   logic [2:0]  IN_FUNCT3 = '0;
   logic [6:0]  IN_FUNCT7 = '0;
   logic [4:0]  IN_RD = '0;
   logic [4:0]  IN_RS1 = '0;
   logic [4:0]  IN_RS2 = '0;
   logic [31:0] IN_IMM = '0;
   logic        OUT_VALID;
   logic        OUT_READY = 1'b0;
   logic [31:0] OUT_INSTR;
   logic        OUT_LAST;
   logic        ERR;

   int n_vec = 0;
   int n_bad = 0;
   logic [32:0] got_q [$];

   typedef struct {
      logic [3:0]  fmt;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [31:0] exp;
   } vec_t;

   inst_encoder dut (
      .CLK(CLK), .RSTn(RSTn), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_FMT(IN_FMT),
      .IN_OPCODE(IN_OPCODE), .IN_FUNCT3(IN_FUNCT3), .IN_FUNCT7(IN_FUNCT7), .IN_RD(IN_RD),
      .IN_RS1(IN_RS1), .IN_RS2(IN_RS2), .IN_IMM(IN_IMM), .OUT_VALID(OUT_VALID),
      .OUT_READY(OUT_READY), .OUT_INSTR(OUT_INSTR), .OUT_LAST(OUT_LAST), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   // Every transfer (valid and ready at the upcoming edge) is logged as {last,instr}.
   always @(negedge CLK) begin
      if (RSTn && OUT_VALID && OUT_READY) got_q.push_back({OUT_LAST, OUT_INSTR});
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Present one bundle and hold it until accepted; returns at #1 after the accepting edge.
   task automatic send(input logic [3:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, output int waits);
      IN_FMT = fmt; IN_OPCODE = op; IN_FUNCT3 = f3; IN_FUNCT7 = f7;
      IN_RD = rd; IN_RS1 = rs1; IN_RS2 = rs2; IN_IMM = imm;
      IN_VALID = 1'b1;
      waits = 0;
      while (!IN_READY && waits < 50) begin
         tick();
         waits++;
      end
      if (!IN_READY) begin
         chk("send_ready_timeout", 64'(IN_READY), 64'd1);
         IN_VALID = 1'b0;
         return;
      end
      tick();
      IN_VALID = 1'b0;
   endtask

   // Wait (bounded) for n logged words, then a little longer to expose extras.
   task automatic wait_words(input int n, input string tag);
      int c = 0;
      while (got_q.size() < n && c < 100) begin
         tick();
         c++;
      end
      tick(3);
      chk({tag, "_count"}, 64'(got_q.size()), 64'(n));
   endtask

   // Illegal or disabled format: ERR pulses one cycle, nothing is emitted.
   task automatic err_case(input logic [3:0] fmt, input string tag);
      int w;
      got_q.delete();
      send(fmt, 7'h73, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'h300, w);
      chk({tag, "_err_hi"}, 64'(ERR), 64'd1);
      chk({tag, "_no_out"}, 64'(OUT_VALID), 64'd0);
      tick();
      chk({tag, "_err_lo"}, 64'(ERR), 64'd0);
      tick(3);
      chk({tag, "_no_words"}, 64'(got_q.size()), 64'd0);
   endtask

   vec_t vt [11];
   vec_t bb [4];

   initial begin
      int w;
      int stalls;
      vt[0]  = '{4'(FMT_LI), 7'h00, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_07FF, 32'h7FF0_0093};
      vt[1]  = '{4'(FMT_LI), 7'h00, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0001_0000, 32'h0001_00B7};
      vt[2]  = '{4'(FMT_LI), 7'h00, 3'd0, 7'h00, 5'd7, 5'd0, 5'd0, 32'h0000_0000, 32'h0000_0393};
      vt[3]  = '{4'(FMT_LI), 7'h00, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'hFFFF_F800, 32'h8000_0113};
      vt[4]  = '{4'(FMT_B),  7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3};
      vt[5]  = '{4'(FMT_B),  7'h63, 3'd1, 7'h00, 5'd0, 5'd3, 5'd4, 32'h0000_0801, 32'h0041_90E3};
      vt[6]  = '{4'(FMT_S),  7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'h0000_0008, 32'h0020_A423};
      vt[7]  = '{4'(FMT_I),  7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'hFFF1_0093};
      vt[8]  = '{4'(FMT_U),  7'h17, 3'd0, 7'h00, 5'd4, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_5217};
      vt[9]  = '{4'(FMT_J),  7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_0008, 32'h0080_00EF};
      vt[10] = '{4'(FMT_J),  7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0000_0801, 32'h0010_006F};
      bb[0]  = '{4'(FMT_R),  7'h33, 3'd0, 7'h00, 5'd1, 5'd1, 5'd2, 32'h0, 32'h0020_80B3};
      bb[1]  = '{4'(FMT_R),  7'h33, 3'd0, 7'h00, 5'd2, 5'd1, 5'd2, 32'h0, 32'h0020_8133};
      bb[2]  = '{4'(FMT_R),  7'h33, 3'd0, 7'h20, 5'd4, 5'd1, 5'd2, 32'h0, 32'h4020_8233};
      bb[3]  = '{4'(FMT_R),  7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0, 32'h0020_81B3};

      // Reset state.
      tick(3);
      chk("rst_in_ready", 64'(IN_READY), 64'd0);
      chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
      chk("rst_out_instr", 64'(OUT_INSTR), 64'd0);
      chk("rst_out_last", 64'(OUT_LAST), 64'd0);
      chk("rst_err", 64'(ERR), 64'd0);
      @(negedge CLK) RSTn = 1'b1;
      tick();
      chk("ready_after_rst", 64'(IN_READY), 64'd1);

      // ADD x3,x1,x2: word one cycle after accept.
      OUT_READY = 1'b1;
      send(4'(FMT_R), 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0, w);
      chk("add_valid", 64'(OUT_VALID), 64'd1);
      chk("add_instr", 64'(OUT_INSTR), 64'h0020_81B3);
      chk("add_last", 64'(OUT_LAST), 64'd1);
      tick(3);
      got_q.delete();

      // Back-to-back R bundles, one per cycle.
      stalls = 0;
      foreach (bb[i]) begin
         send(bb[i].fmt, bb[i].op, bb[i].f3, bb[i].f7, bb[i].rd, bb[i].rs1, bb[i].rs2, bb[i].imm, w);
         stalls += w;
      end
      chk("b2b_stalls", 64'(stalls), 64'd0);
      wait_words(4, "b2b");
      foreach (bb[i]) chk($sformatf("b2b_word%0d", i), 64'(got_q[i]), 64'({1'b1, bb[i].exp}));
      got_q.delete();

      // LI x5,0x12345FFF: LUI then ADDI, IN_READY low in between.
      send(4'(FMT_LI), 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF, w);
      chk("li2_lui", 64'(OUT_INSTR), 64'h1234_62B7);
      chk("li2_lui_last", 64'(OUT_LAST), 64'd0);
      chk("li2_ready_low", 64'(IN_READY), 64'd0);
      tick();
      chk("li2_addi", 64'(OUT_INSTR), 64'hFFF2_8293);
      chk("li2_addi_last", 64'(OUT_LAST), 64'd1);
      chk("li2_ready_back", 64'(IN_READY), 64'd1);
      tick(3);
      chk("li2_count", 64'(got_q.size()), 64'd2);
      got_q.delete();

      // Single-word formats and LI boundary cases.
      foreach (vt[i]) begin
         send(vt[i].fmt, vt[i].op, vt[i].f3, vt[i].f7, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].imm, w);
         wait_words(1, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d_word", i), 64'(got_q[0]), 64'({1'b1, vt[i].exp}));
         got_q.delete();
      end

      // Backpressure during LI: head holds, then both words drain in order.
      OUT_READY = 1'b0;
      send(4'(FMT_LI), 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF, w);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_hold%0d", i), 64'({OUT_VALID, OUT_LAST, OUT_INSTR}),
             64'({1'b1, 1'b0, 32'h1234_62B7}));
         tick();
      end
      OUT_READY = 1'b1;
      wait_words(2, "bp");
      chk("bp_word0", 64'(got_q[0]), 64'({1'b0, 32'h1234_62B7}));
      chk("bp_word1", 64'(got_q[1]), 64'({1'b1, 32'hFFF2_8293}));
      got_q.delete();

      // Reset after the LUI: everything flushed, no ADDI appears.
      OUT_READY = 1'b0;
      send(4'(FMT_LI), 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF, w);
      chk("rst_mid_lui", 64'(OUT_INSTR), 64'h1234_62B7);
      RSTn = 1'b0;
      #1;
      chk("rst_mid_valid", 64'(OUT_VALID), 64'd0);
      tick();
      RSTn = 1'b1;
      OUT_READY = 1'b1;
      tick(5);
      chk("rst_mid_no_words", 64'(got_q.size()), 64'd0);
      chk("rst_mid_valid_after", 64'(OUT_VALID), 64'd0);
      chk("rst_mid_ready_after", 64'(IN_READY), 64'd1);

      // System formats.
`ifdef INST_ENC_SYSTEM_EN
      send(4'(FMT_MRET), 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0, w);
      chk("mret_word", 64'({OUT_VALID, OUT_LAST, OUT_INSTR}), 64'({1'b1, 1'b1, 32'h3020_0073}));
      chk("mret_no_err", 64'(ERR), 64'd0);
      tick(3);
      send(4'(FMT_CSR), 7'h00, 3'd1, 7'h00, 5'd1, 5'd2, 5'd0, 32'h0000_0300, w);
      chk("csr_word", 64'({OUT_VALID, OUT_LAST, OUT_INSTR}), 64'({1'b1, 1'b1, 32'h3001_10F3}));
      tick(3);
`else
      err_case(4'(FMT_MRET), "mret_off");
      err_case(4'(FMT_CSR), "csr_off");
`endif
      err_case(4'hF, "fmt_f");
      err_case(4'h9, "fmt_9");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got time %0t, expected < 200000", $time);
      $fatal(1, "watchdog");
   end

endmodule
